// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues one word read at a time to
// instruction memory and buffers returned {instr, pc} pairs in a 2-entry FIFO.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid (and its payload) never depends on ready and holds until
  // the transfer, except that a redirect may withdraw an unaccepted request.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] instr_q [2];
  logic [31:0] epc_q   [2];

  logic accept;
  logic push;
  logic pop;

  assign imem_req_valid = (state_q == S_REQ) && (count_q != 2'd2);
  assign imem_addr      = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign out_valid = (count_q != 2'd0);
  assign out_instr = instr_q[rd_ptr_q];
  assign out_pc    = epc_q[rd_ptr_q];
  assign out_pc4   = epc_q[rd_ptr_q] + 32'd4;
  assign dbg_state = state_q;

  // Fetch sequencing; a redirect overrides whatever the normal path decided.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'd3;
      push = 1'b0;
      case (state_q)
        S_REQ:   state_d = accept ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Output buffer bookkeeping; a flush wins over a same-cycle pop.
  always_comb begin
    pop      = out_valid && out_ready && !redirect_valid;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'd0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= 32'd0;
        epc_q[i]   <= 32'd0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) begin
        instr_q[wr_ptr_q] <= imem_rdata;
        epc_q[wr_ptr_q]   <= req_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: address-echo memory with adjustable
// latency, expected-PC queue for every consumed instruction.
module tb_mips_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_REQ  = 2'd1;
  localparam logic [1:0]  ST_WAIT = 2'd2;
  localparam logic [1:0]  ST_DROP = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_pop = 0;
  int pop_gap  = 0;
  int acc_cnt  = 0;
  int mem_lat  = 1;
  int mem_cnt  = 0;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] exp_q[$];
  logic        found;

  mips_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: scoreboard the pop, advance the memory model, settle #1 after the edge.
  task automatic tick();
    logic        acc;
    logic        pop;
    logic [31:0] a;
    logic [31:0] e;
    acc = imem_req_valid && imem_req_ready && rst_n;
    a   = imem_addr;
    pop = out_valid && out_ready && !redirect_valid && rst_n;
    if (pop) begin
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_pc", out_pc, e);
        chk("pop_instr", out_instr, e);
        chk("pop_pc4", out_pc4, e + 32'd4);
      end
      pop_gap  = cyc - last_pop;
      last_pop = cyc;
    end
    if (acc) acc_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (imem_rsp_valid) mem_pend = 1'b0;
    if (acc) begin
      mem_pend = 1'b1;
      mem_addr = a;
      mem_cnt  = mem_lat - 1;
    end else if (mem_pend && mem_cnt > 0) begin
      mem_cnt--;
    end
    imem_rsp_valid = mem_pend && (mem_cnt == 0);
    imem_rdata     = imem_rsp_valid ? mem_addr : 32'hDEAD_BEEF;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rdata     = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b1;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pc4", out_pc4, 32'd4);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset release and streaming with a zero-wait memory
    tick();
    chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c1_addr", imem_addr, RST_PC);
    chk("c1_state", 32'(dbg_state), 32'(ST_REQ));
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    tick();
    chk("wait_state", 32'(dbg_state), 32'(ST_WAIT));
    chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_out_pc", out_pc, 32'h100);
    drain("stream");
    chk("stream_gap", 32'(pop_gap), 32'd2);

    // Backpressure: buffer fills to two and fetching stops
    out_ready = 1'b0;
    acc_cnt   = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_accepts", 32'(acc_cnt), 32'd1);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head_pc", out_pc, 32'h10C);
    out_ready = 1'b1;
    exp_q.push_back(32'h10C);
    exp_q.push_back(32'h110);
    exp_q.push_back(32'h114);
    tick();
    chk("bp_resume_valid", 32'(imem_req_valid), 32'd1);
    chk("bp_resume_addr", imem_addr, 32'h114);
    drain("bp");

    // Memory stalls the request: address must hold
    imem_req_ready = 1'b0;
    exp_q.push_back(32'h118);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_addr", imem_addr, 32'h11C);
      chk("stall_valid", 32'(imem_req_valid), 32'd1);
    end

    // Redirect while waiting; the stale response comes back later
    imem_req_ready = 1'b1;
    mem_lat        = 4;
    tick();
    chk("rw_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2003;
    tick();
    redirect_valid = 1'b0;
    chk("rw_state_drop", 32'(dbg_state), 32'(ST_DROP));
    chk("rw_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rw_out_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    chk("rw_stale_rsp", 32'(imem_rsp_valid), 32'd1);
    tick();
    chk("rw_new_valid", 32'(imem_req_valid), 32'd1);
    chk("rw_new_addr", imem_addr, 32'h2000);
    mem_lat = 1;
    exp_q.push_back(32'h2000);
    drain("rw");

    // Redirect in the same cycle as a request accept
    tick();
    chk("ra_pre_addr", imem_addr, 32'h2008);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    tick();
    redirect_valid = 1'b0;
    chk("ra_out_valid", 32'(out_valid), 32'd0);
    chk("ra_state", 32'(dbg_state), 32'(ST_DROP));
    tick();
    chk("ra_new_addr", imem_addr, 32'h3000);
    chk("ra_new_valid", 32'(imem_req_valid), 32'd1);
    exp_q.push_back(32'h3000);
    drain("ra");

    // Redirect in the same cycle as a response, with one entry buffered and a pop offered
    out_ready = 1'b0;
    tick();
    tick();
    chk("rr_pre_valid", 32'(out_valid), 32'd1);
    chk("rr_pre_pc", out_pc, 32'h3004);
    chk("rr_pre_rsp", 32'(imem_rsp_valid), 32'd1);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    tick();
    redirect_valid = 1'b0;
    chk("rr_out_valid", 32'(out_valid), 32'd0);
    chk("rr_state", 32'(dbg_state), 32'(ST_REQ));
    chk("rr_new_addr", imem_addr, 32'h4000);
    exp_q.push_back(32'h4000);
    drain("rr");

    // PC wrap at the top of the address space; low target bits ignored
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    out_ready = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_out_pc4", out_pc4, 32'h0000_0000);
    chk("wrap_out_instr", out_instr, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    out_ready = 1'b1;
    drain("wrap");

    // Asynchronous reset mid-WAIT with a buffered instruction
    out_ready = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = out_valid && (dbg_state == ST_WAIT);
    end
    chk("ar_setup", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_req_valid", 32'(imem_req_valid), 32'd0);
    chk("ar_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("ar_out_pc4", out_pc4, 32'd4);
    mem_pend       = 1'b0;
    imem_rsp_valid = 1'b0;
    tick();
    mem_pend       = 1'b0;
    imem_rsp_valid = 1'b0;
    rst_n          = 1'b1;
    tick();
    chk("ar_refetch_addr", imem_addr, RST_PC);
    chk("ar_refetch_valid", 32'(imem_req_valid), 32'd1);
    out_ready = 1'b1;
    exp_q.push_back(RST_PC);
    drain("ar");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
